// File: rtl/dds_panel_ctrl_if.sv
// rtl/dds_panel_ctrl_if.sv - panel button / DDS configuration handshake bundle
//
// Purpose: groups the button pulses and the configuration valid/ready
// handshake of dds_panel_ctrl into one interface.
// Ports (signals):
//   BtnMode, BtnUp, BtnDown  button pulses into the controller
//   CfgReady                 DDS core accepts the configuration
//   CfgValid, Ftw, Amp, Wave configuration published to the DDS core
//   Sel, Busy                panel status
// Modports: master drives buttons/ready, slave is the controller.
interface dds_panel_ctrl_if #(
  parameter int FTW_W = 32,
  parameter int AMP_W = 8
);
  logic             BtnMode;
  logic             BtnUp;
  logic             BtnDown;
  logic             CfgReady;
  logic             CfgValid;
  logic [FTW_W-1:0] Ftw;
  logic [AMP_W-1:0] Amp;
  logic [1:0]       Wave;
  logic [1:0]       Sel;
  logic             Busy;

  modport master (
    output BtnMode, BtnUp, BtnDown, CfgReady,
    input  CfgValid, Ftw, Amp, Wave, Sel, Busy
  );

  modport slave (
    input  BtnMode, BtnUp, BtnDown, CfgReady,
    output CfgValid, Ftw, Amp, Wave, Sel, Busy
  );
endinterface

// File: rtl/dds_panel_ctrl.sv
// rtl/dds_panel_ctrl.sv - front-panel controller publishing DDS configuration
//
// Purpose: decodes Mode/Up/Down pulses, keeps tuning word, amplitude and
// waveform, and publishes each change over a valid/ready handshake with a
// one-deep pending slot for events arriving while a publish is outstanding.
// Ports:
//   Fg_CLK   system clock
//   RESETn   asynchronous active-low reset
//   cfg      dds_panel_ctrl_if.slave (buttons, CfgReady in; CfgValid,
//            Ftw, Amp, Wave, Sel, Busy out)
// Build option: FREQ_WRAP_EN - frequency steps past a limit wrap to the
// opposite limit instead of saturating.
module dds_panel_ctrl #(
  parameter int               FTW_W     = 32,
  parameter logic [FTW_W-1:0] FTW_RESET = 32'd100000,
  parameter logic [FTW_W-1:0] FTW_STEP  = 32'd10000,
  parameter logic [FTW_W-1:0] FTW_MIN   = 32'd10000,
  parameter logic [FTW_W-1:0] FTW_MAX   = 32'd2000000000,
  parameter int               AMP_W     = 8,
  parameter int               AMP_STEP  = 16,
  parameter int               WAVE_N    = 4
) (
  input logic               Fg_CLK,
  input logic               RESETn,
  dds_panel_ctrl_if.slave   cfg
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PUBLISH} state_t;

  localparam logic [1:0] SEL_FREQ = 2'd0;
  localparam logic [1:0] SEL_AMP  = 2'd1;
  localparam logic [1:0] SEL_WAVE = 2'd2;

  localparam logic [FTW_W:0] STEP_X = {1'b0, FTW_STEP};
  localparam logic [FTW_W:0] MIN_X  = {1'b0, FTW_MIN};
  localparam logic [FTW_W:0] MAX_X  = {1'b0, FTW_MAX};
`ifdef FREQ_WRAP_EN
  localparam logic [FTW_W-1:0] FTW_OVER  = FTW_MIN;
  localparam logic [FTW_W-1:0] FTW_UNDER = FTW_MAX;
`else
  localparam logic [FTW_W-1:0] FTW_OVER  = FTW_MAX;
  localparam logic [FTW_W-1:0] FTW_UNDER = FTW_MIN;
`endif

  localparam logic [AMP_W:0]   AMP_STEP_X = (AMP_W+1)'(AMP_STEP);
  localparam logic [AMP_W:0]   AMP_MAX_X  = {1'b0, {AMP_W{1'b1}}};
  localparam logic [1:0]       WAVE_LAST  = 2'(WAVE_N - 1);

  state_t           state, state_n;
  logic [FTW_W-1:0] ftw, ftw_n, ftw_cand;
  logic [AMP_W-1:0] amp, amp_n, amp_cand;
  logic [1:0]       wave, wave_n, wave_cand;
  logic [1:0]       sel, sel_n;
  logic             pend_valid, pend_valid_n;
  logic             pend_up, pend_up_n;
  logic [1:0]       pend_sel, pend_sel_n;

  logic [FTW_W:0]   ftw_sum;
  logic [AMP_W:0]   amp_sum;
  logic             ev_up, ev_dn, ev;
  logic             ap_up;
  logic [1:0]       ap_sel;
  logic             changed;

  // Mode wins over Up/Down; Up with Down cancels.
  assign ev_up = cfg.BtnUp & ~cfg.BtnDown & ~cfg.BtnMode;
  assign ev_dn = cfg.BtnDown & ~cfg.BtnUp & ~cfg.BtnMode;
  assign ev    = ev_up | ev_dn;

  // In IDLE a held pending event takes priority over a fresh one.
  assign ap_up  = pend_valid ? pend_up  : ev_up;
  assign ap_sel = pend_valid ? pend_sel : sel;

  // Candidate parameter values for the event being applied.
  always_comb begin
    ftw_cand  = ftw;
    amp_cand  = amp;
    wave_cand = wave;
    ftw_sum   = '0;
    amp_sum   = '0;
    case (ap_sel)
      SEL_FREQ: begin
        if (ap_up) begin
          ftw_sum = {1'b0, ftw} + STEP_X;
          ftw_cand = (ftw_sum > MAX_X) ? FTW_OVER : ftw_sum[FTW_W-1:0];
        end else begin
          ftw_sum = {1'b0, ftw} - STEP_X;
          // MSB set means the subtraction borrowed below zero.
          ftw_cand = (ftw_sum[FTW_W] || ftw_sum < MIN_X) ? FTW_UNDER
                                                         : ftw_sum[FTW_W-1:0];
        end
      end
      SEL_AMP: begin
        if (ap_up) begin
          amp_sum = {1'b0, amp} + AMP_STEP_X;
          amp_cand = (amp_sum > AMP_MAX_X) ? {AMP_W{1'b1}} : amp_sum[AMP_W-1:0];
        end else begin
          amp_sum = {1'b0, amp} - AMP_STEP_X;
          amp_cand = amp_sum[AMP_W] ? '0 : amp_sum[AMP_W-1:0];
        end
      end
      SEL_WAVE: begin
        if (ap_up) wave_cand = (wave == WAVE_LAST) ? 2'd0 : wave + 2'd1;
        else       wave_cand = (wave == 2'd0) ? WAVE_LAST : wave - 2'd1;
      end
      default: ;
    endcase
  end

  assign changed = (ftw_cand != ftw) || (amp_cand != amp) || (wave_cand != wave);

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    ftw_n        = ftw;
    amp_n        = amp;
    wave_n       = wave;
    pend_valid_n = pend_valid;
    pend_up_n    = pend_up;
    pend_sel_n   = pend_sel;

    if (cfg.BtnMode) sel_n = (sel == SEL_WAVE) ? SEL_FREQ : sel + 2'd1;

    case (state)
      ST_INIT, ST_PUBLISH: begin
        if (state == ST_INIT)  state_n = ST_PUBLISH;
        else if (cfg.CfgReady) state_n = ST_IDLE;
        if (ev && !pend_valid) begin
          pend_valid_n = 1'b1;
          pend_up_n    = ev_up;
          pend_sel_n   = sel;
        end
      end
      ST_IDLE: begin
        if ((pend_valid || ev) && changed) begin
          ftw_n   = ftw_cand;
          amp_n   = amp_cand;
          wave_n  = wave_cand;
          state_n = ST_PUBLISH;
        end
        // Draining the slot frees it for an event arriving this same cycle.
        if (pend_valid) begin
          pend_valid_n = ev;
          pend_up_n    = ev_up;
          pend_sel_n   = sel;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_INIT;
      ftw        <= FTW_RESET;
      amp        <= {AMP_W{1'b1}};
      wave       <= 2'd0;
      sel        <= SEL_FREQ;
      pend_valid <= 1'b0;
      pend_up    <= 1'b0;
      pend_sel   <= SEL_FREQ;
    end else begin
      state      <= state_n;
      ftw        <= ftw_n;
      amp        <= amp_n;
      wave       <= wave_n;
      sel        <= sel_n;
      pend_valid <= pend_valid_n;
      pend_up    <= pend_up_n;
      pend_sel   <= pend_sel_n;
    end
  end

  assign cfg.CfgValid = (state == ST_PUBLISH);
  assign cfg.Busy     = (state == ST_PUBLISH) || pend_valid;
  assign cfg.Ftw      = ftw;
  assign cfg.Amp      = amp;
  assign cfg.Wave     = wave;
  assign cfg.Sel      = sel;

endmodule

// File: tb/tb_dds_panel_ctrl.sv
// tb/tb_dds_panel_ctrl.sv - randomized self-checking bench for dds_panel_ctrl
module tb_dds_panel_ctrl;

  localparam longint STEP   = 10000;
  localparam longint FMIN   = 10000;
  localparam longint FMAX   = 195000;
  localparam longint FRESET = 100000;
  localparam int     ASTEP  = 16;
  localparam int     AMAX   = 255;
  localparam int     WAVES  = 4;
`ifdef FREQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_panel_ctrl_if #(.FTW_W(32), .AMP_W(8)) cfg ();

  dds_panel_ctrl #(.FTW_MAX(32'd195000)) dut (
    .Fg_CLK (clk),
    .RESETn (rst_n),
    .cfg    (cfg)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { bit up; int sel; } ev_t;
  ev_t    pq[$];
  longint m_ftw;
  int     m_amp, m_wave, m_sel;
  bit     m_pub, m_init;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ftw = FRESET; m_amp = AMAX; m_wave = 0; m_sel = 0;
    m_pub = 0; m_init = 1; pq.delete();
  endtask

  task automatic m_apply(input ev_t e);
    longint t;
    int a, w;
    case (e.sel)
      0: begin
        t = e.up ? m_ftw + STEP : m_ftw - STEP;
        if (t > FMAX)      t = WRAP ? FMIN : FMAX;
        else if (t < FMIN) t = WRAP ? FMAX : FMIN;
        if (t != m_ftw) begin m_ftw = t; m_pub = 1; end
      end
      1: begin
        a = e.up ? m_amp + ASTEP : m_amp - ASTEP;
        if (a > AMAX) a = AMAX;
        if (a < 0)    a = 0;
        if (a != m_amp) begin m_amp = a; m_pub = 1; end
      end
      2: begin
        w = (m_wave + (e.up ? 1 : WAVES - 1)) % WAVES;
        if (w != m_wave) begin m_wave = w; m_pub = 1; end
      end
      default: ;
    endcase
  endtask

  // One clock edge of panel behaviour, seen from the spec's event rules.
  task automatic m_step(input bit mode, input bit up, input bit dn, input bit rdy);
    bit   has;
    ev_t  ne, e;
    has = (up ^ dn) && !mode;
    ne.up = up; ne.sel = m_sel;
    if (m_init) begin
      m_init = 0; m_pub = 1;
      if (has && pq.size() == 0) pq.push_back(ne);
    end else if (m_pub) begin
      if (rdy) m_pub = 0;
      if (has && pq.size() == 0) pq.push_back(ne);
    end else if (pq.size() != 0) begin
      e = pq.pop_front();
      if (has) pq.push_back(ne);
      m_apply(e);
    end else if (has) begin
      m_apply(ne);
    end
    if (mode) m_sel = (m_sel + 1) % 3;
  endtask

  task automatic compare_all();
    chk("valid", cfg.CfgValid, m_pub);
    chk("ftw",   cfg.Ftw,      m_ftw);
    chk("amp",   cfg.Amp,      m_amp);
    chk("wave",  cfg.Wave,     m_wave);
    chk("sel",   cfg.Sel,      m_sel);
    chk("busy",  cfg.Busy,     (m_pub || pq.size() != 0));
  endtask

  task automatic cyc(input bit mode, input bit up, input bit dn, input bit rdy);
    cfg.BtnMode = mode; cfg.BtnUp = up; cfg.BtnDown = dn; cfg.CfgReady = rdy;
    @(posedge clk);
    m_step(mode, up, dn, rdy);
    #1;
    compare_all();
    cfg.BtnMode = 0; cfg.BtnUp = 0; cfg.BtnDown = 0;
  endtask

  initial begin
    cfg.BtnMode = 0; cfg.BtnUp = 0; cfg.BtnDown = 0; cfg.CfgReady = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", cfg.CfgValid, 0);
    chk("rst_ftw",   cfg.Ftw, 100000);
    chk("rst_amp",   cfg.Amp, 255);
    chk("rst_busy",  cfg.Busy, 0);
    rst_n = 1;

    // Defaults pushed once after release.
    cyc(0, 0, 0, 1);
    chk("init_pub", cfg.CfgValid, 1);
    chk("init_ftw", cfg.Ftw, 100000);
    cyc(0, 0, 0, 1);
    chk("init_done", cfg.CfgValid, 0);

    // Single Up with ready held high.
    cyc(0, 1, 0, 1);
    chk("up_ftw", cfg.Ftw, 110000);
    chk("up_pub", cfg.CfgValid, 1);
    cyc(0, 0, 0, 1);
    chk("up_one_cycle", cfg.CfgValid, 0);

    // Stalled publish: Up publishes, second Up pends, Down dropped.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (8) cyc(0, 0, 0, 0);
    chk("stall_hold", cfg.Ftw, 120000);
    cyc(0, 0, 0, 1);
    chk("hs_gap", cfg.CfgValid, 0);
    cyc(0, 0, 0, 1);
    chk("pend_ftw", cfg.Ftw, 130000);
    repeat (2) cyc(0, 0, 0, 1);
    chk("pend_busy", cfg.Busy, 0);

    // Waveform selection and wrap-down.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("sel_wave", cfg.Sel, 2);
    cyc(0, 0, 1, 1);
    chk("wave3", cfg.Wave, 3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("wave2", cfg.Wave, 2);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1);
    chk("mode_up_sel", cfg.Sel, 0);
    chk("mode_up_nopub", cfg.CfgValid, 0);

    // Frequency upper limit.
    for (int i = 0; i < 40 && m_ftw < FMAX - 5000; i++) begin
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
    end
    chk("near_max", cfg.Ftw, 190000);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
`ifdef FREQ_WRAP_EN
    chk("wrap_pub", cfg.CfgValid, 1);
`else
    chk("sat_max", cfg.Ftw, 195000);
    chk("sat_nopub", cfg.CfgValid, 0);
`endif
    cyc(0, 0, 0, 1);

    // Amplitude lower saturation.
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 1);
    end
    chk("amp_zero", cfg.Amp, 0);
    cyc(0, 0, 1, 1);
    chk("amp_nopub", cfg.CfgValid, 0);

    // Asynchronous reset during a stalled publish.
    cyc(0, 1, 0, 0);
    chk("pre_rst_pub", cfg.CfgValid, 1);
    #3 rst_n = 0;
    #1;
    m_reset();
    chk("arst_valid", cfg.CfgValid, 0);
    chk("arst_amp",   cfg.Amp, 255);
    chk("arst_sel",   cfg.Sel, 0);
    chk("arst_busy",  cfg.Busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 0, 1);
    chk("rerun_pub", cfg.CfgValid, 1);
    chk("rerun_ftw", cfg.Ftw, 100000);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
